instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Bus initiator for the instruction memory. Drives the read side of the mem_* bus
//  (mem_addr, mem_renable; read data one cycle later). Buffers fetched words in a small
//  FIFO and delivers them to decode over a valid/ready handshake.
//  Sits between the instruction memory and the decode stage of the RV32I core.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset; bits[1:0] must be 0
//  FIFO_DEPTH  4              prefetch buffer entries; power of 2, >= 2
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  resetn          in   1   asynchronous, active-low reset
//  fetch_en        in   1   1 = issue fetches; 0 = stop issuing, drain in-flight read
//  redirect_valid  in   1   branch/jump taken; flush and restart at redirect_pc
//  redirect_pc     in   32  new fetch address; bits[1:0] ignored (treated as 0)
//  mem_addr        out  32  byte address to instruction memory, word aligned
//  mem_renable     out  1   read request, one word per asserted cycle
//  mem_rdata       in   32  read data, valid the cycle after mem_renable=1
//  mem_wdata       out  32  tied 32'h0 (initiator never writes)
//  mem_mask        out  4   tied 4'b0000
//  instr_valid     out  1   instr_data/instr_pc valid
//  instr_data      out  32  instruction word at FIFO head
//  instr_pc        out  32  address of instr_data
//  instr_ready     in   1   decode accepts; transfer when instr_valid & instr_ready
// BEHAVIOUR
//  Reset: pc=RESET_PC, mem_addr=RESET_PC, mem_renable=0, FIFO empty, instr_valid=0,
//   instr_data=0, instr_pc=0, inflight=0, state=IDLE. Reset mid-operation drops all.
//  FSM: IDLE -> RUN when fetch_en=1; RUN -> IDLE when fetch_en=0 (in-flight read
//   still lands in FIFO). Redirect is legal in either state.
//  Issue (RUN): mem_renable=1 when (count + inflight) < FIFO_DEPTH and !redirect_valid;
//   mem_addr=pc; pc <= pc+4 (32-bit wrap 32'hFFFF_FFFC -> 0). Back-to-back issue each
//   cycle gives 1 word/cycle throughput.
//  Response: cycle after issue, mem_rdata and its pc are pushed to the FIFO
//   (inflight=1 marks the slot, never overflows by construction).
//  Pop: when instr_valid & instr_ready the head advances; push and pop in the same
//   cycle keep count unchanged. Full: issue suppressed. Empty: instr_valid=0.
//  Redirect (highest priority): same cycle FIFO flushed (count=0, instr_valid=0 next
//   cycle), pop ignored, no issue; pc <= {redirect_pc[31:2],2'b00}; the response of any
//   read issued the previous cycle is discarded. First issue of new pc on next cycle
//   (fetch_en=1). Redirect on consecutive cycles: last one wins.
//  Latency redirect -> instr_valid: 3 cycles (issue, response, FIFO head) without bypass.
//  mem_addr holds its last value while mem_renable=0.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: when FIFO empty and a non-discarded response arrives,
//   instr_valid/instr_data/instr_pc are driven combinationally from mem_rdata in that
//   cycle; if instr_ready=1 the word is consumed and not pushed. Redirect latency = 2.
//  FETCH_BYPASS_EN undefined: outputs come only from FIFO head registers; no
//   combinational mem_rdata -> instr_data path.
// TESTING
//  1 Reset, RESET_PC=0, fetch_en=1, instr_ready=1, MEM[0..3]=A0..A3 -> mem_addr 0,4,8,C
//    on consecutive cycles; instr_data A0..A3 with instr_pc 0,4,8,C, one per cycle.
//  2 instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 issues, mem_renable then 0;
//    release ready -> words 0,4,8,C in order, issue resumes at 0x10, none lost/duplicated.
//  3 Redirect to 0x103 while read of 0x8 in flight -> 0x8 word dropped, next mem_addr
//    0x100, first instr_pc 0x100, FIFO contents before redirect never appear.
//  4 Redirect and instr_ready=1 with instr_valid=1 same cycle -> head not counted as
//    consumed twice; next valid word is from 0x100.
//  5 fetch_en 1->0 mid-stream -> one outstanding word still delivered, then no issue;
//    fetch_en back to 1 -> resumes at following address. Assert resetn low mid-stream
//    -> instr_valid=0 immediately, restart at RESET_PC.
//  6 Run both with and without FETCH_BYPASS_EN: redirect-to-instr_valid = 2 vs 3 cycles.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: issues word reads, buffers responses in a prefetch FIFO,
// hands them to decode over valid/ready. Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] mem_addr,
   output logic        mem_renable,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_mask,
   output logic        instr_valid,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0]   LP_DEPTH = (CW+1)'(FIFO_DEPTH);
   localparam logic [AW-1:0] LP_ONE_A = 1;
   localparam logic [CW-1:0] LP_ONE_C = 1;

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t        r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_mem_addr;
   logic          r_inflight;
   logic [31:0]   r_inflight_pc;
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [31:0]   r_fifo_data [FIFO_DEPTH];
   logic [31:0]   r_fifo_pc   [FIFO_DEPTH];

   logic          w_fifo_empty;
   logic [CW:0]   w_occupancy;
   logic          w_issue;
   logic          w_resp;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;
   logic          w_unused;

   assign w_unused     = ^redirect_pc[1:0];
   assign w_fifo_empty = (r_count == '0);

   // Slots already promised to the read in flight count against capacity, so a
   // response can always be pushed without an overflow check.
   assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_issue     = (r_state == S_RUN) && fetch_en && !redirect_valid &&
                        (w_occupancy < LP_DEPTH);
   assign w_resp      = r_inflight && !redirect_valid;

`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_fifo_empty && w_resp;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_pop  = !w_fifo_empty && instr_ready && !redirect_valid;
   assign w_push = w_resp && !(w_bypass && instr_ready);

   assign mem_renable = w_issue;
   assign mem_addr    = w_issue ? r_pc : r_mem_addr;
   assign mem_wdata   = 32'h0000_0000;
   assign mem_mask    = 4'b0000;

   always_comb begin
      instr_valid = 1'b0;
      instr_data  = 32'h0000_0000;
      instr_pc    = 32'h0000_0000;
      if (!w_fifo_empty) begin
         instr_valid = 1'b1;
         instr_data  = r_fifo_data[r_head];
         instr_pc    = r_fifo_pc[r_head];
      end
`ifdef FETCH_BYPASS_EN
      else if (w_bypass) begin
         instr_valid = 1'b1;
         instr_data  = mem_rdata;
         instr_pc    = r_inflight_pc;
      end
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_mem_addr    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= 32'h0000_0000;
      end else begin
         case (r_state)
            S_IDLE:  if (fetch_en)  r_state <= S_RUN;
            S_RUN:   if (!fetch_en) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         r_inflight <= w_issue;
         if (w_issue) begin
            r_mem_addr    <= r_pc;
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
         end
         // Issue is blocked during a redirect, so the two pc updates never collide.
         if (redirect_valid)
            r_pc <= {redirect_pc[31:2], 2'b00};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (redirect_valid) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + LP_ONE_A;
         if (w_pop)  r_head <= r_head + LP_ONE_A;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LP_ONE_C;
            2'b01:   r_count <= r_count - LP_ONE_C;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; outputs are gated by the count, so stale slots never show.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_tail] <= mem_rdata;
         r_fifo_pc[r_tail]   <= r_inflight_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic checked every
// cycle against a queue-based model of the prefetch buffer and the fetch address stream.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP     = 1'b1;
   localparam int EXP_LAT = 2;
   localparam int EXP_T5  = 1;
`else
   localparam bit BYP     = 1'b0;
   localparam int EXP_LAT = 3;
   localparam int EXP_T5  = 2;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_ready = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_renable;
   logic [31:0] mem_rdata;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_mask;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_addr(mem_addr), .mem_renable(mem_renable), .mem_rdata(mem_rdata),
      .mem_wdata(mem_wdata), .mem_mask(mem_mask),
      .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   // Memory image: word at byte address a is (a>>2) ^ A000_0000, so MEM[0..3] = A0000000..A0000003.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a >> 2) ^ 32'hA000_0000;
   endfunction

   logic        mem_pend = 1'b0;
   logic [31:0] mem_paddr = 32'h0;
   always @(posedge clk) begin
      mem_pend  <= mem_renable;
      mem_paddr <= mem_addr;
   end
   assign mem_rdata = mem_pend ? memf(mem_paddr) : 32'hDEAD_BEEF;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model state
   logic [31:0] q_pc[$];
   bit          m_infl = 1'b0;
   bit          m_run = 1'b0;
   logic [31:0] m_infl_pc = 32'h0;
   logic [31:0] m_issue_pc = RESET_PC;

   // Observation counters, cleared whenever the stimulus bumps mark_id
   int          cyc = 0;
   int          mark_id = 0;
   int          mark_seen = 0;
   int          n_issue = 0;
   int          n_xfer = 0;
   bit          got_issue = 1'b0;
   logic [31:0] first_issue = 32'h0;
   logic [31:0] xlog_pc [8];
   int          xlog_cyc [8];
   bit          lat_open = 1'b0;
   int          rv_cyc = 0;
   int          lat = -1;

   always @(negedge clk) begin
      bit          byp;
      bit          exp_valid;
      bit          exp_ren;
      logic [31:0] exp_pc;
      cyc++;
      if (mark_seen != mark_id) begin
         mark_seen = mark_id;
         n_issue   = 0;
         n_xfer    = 0;
         got_issue = 1'b0;
         for (int i = 0; i < 8; i++) begin
            xlog_pc[i]  = 32'hFFFF_FFFF;
            xlog_cyc[i] = 0;
         end
      end
      if (!resetn) begin
         q_pc.delete();
         m_infl     = 1'b0;
         m_run      = 1'b0;
         m_issue_pc = RESET_PC;
         lat_open   = 1'b0;
      end else begin
         byp       = BYP && (q_pc.size() == 0) && m_infl && !redirect_valid;
         exp_valid = (q_pc.size() != 0) || byp;
         exp_pc    = (q_pc.size() != 0) ? q_pc[0] : m_infl_pc;
         exp_ren   = m_run && fetch_en && !redirect_valid &&
                     ((q_pc.size() + int'(m_infl)) < DEPTH);

         chk("instr_valid", {31'h0, instr_valid}, {31'h0, exp_valid});
         if (exp_valid) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr_data", instr_data, memf(exp_pc));
         end
         chk("mem_renable", {31'h0, mem_renable}, {31'h0, exp_ren});
         if (exp_ren) chk("mem_addr", mem_addr, m_issue_pc);
         chk("mem_wdata_mask", mem_wdata | {28'h0, mem_mask}, 32'h0);

         if (mem_renable) begin
            n_issue++;
            if (!got_issue) begin
               got_issue   = 1'b1;
               first_issue = mem_addr;
            end
         end
         if (lat_open && instr_valid) begin
            lat      = cyc - rv_cyc;
            lat_open = 1'b0;
         end

         if (redirect_valid) begin
            q_pc.delete();
            m_infl     = 1'b0;
            m_issue_pc = {redirect_pc[31:2], 2'b00};
            lat_open   = 1'b1;
            rv_cyc     = cyc;
            lat        = -1;
         end else begin
            if (exp_valid && instr_ready) begin
               if (n_xfer < 8) begin
                  xlog_pc[n_xfer]  = instr_pc;
                  xlog_cyc[n_xfer] = cyc;
               end
               n_xfer++;
               if (q_pc.size() != 0) void'(q_pc.pop_front());
            end
            if (m_infl && !(byp && instr_ready)) q_pc.push_back(m_infl_pc);
            m_infl = exp_ren;
            if (exp_ren) begin
               m_infl_pc  = m_issue_pc;
               m_issue_pc = m_issue_pc + 32'd4;
            end
         end
         m_run = fetch_en;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      mark_id++;
      step(1);
      redirect_valid = 1'b0;
   endtask

   logic [31:0] t1_pc   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
   logic [31:0] t1_data [4] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};

   initial begin
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      step(2);
      chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_mem_renable", {31'h0, mem_renable}, 32'h0);
      chk("rst_mem_addr", mem_addr, RESET_PC);
      chk("rst_instr_data", instr_data, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);

      // 1: streaming from reset, one word per cycle
      resetn = 1'b1;
      mark_id++;
      step(8);
      chk("t1_first_issue", first_issue, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("t1_pc", xlog_pc[i], t1_pc[i]);
         chk("t1_data", memf(xlog_pc[i]), t1_data[i]);
      end
      chk("t1_rate", 32'(xlog_cyc[3] - xlog_cyc[0]), 32'd3);

      // 2: decode stalled, issue stops at FIFO_DEPTH, then resumes in order
      instr_ready = 1'b0;
      redirect_to(32'h0);
      mark_id++;
      step(10);
      chk("t2_issues", 32'(n_issue), 32'd4);
      instr_ready = 1'b1;
      mark_id++;
      step(8);
      chk("t2_resume_addr", first_issue, 32'h10);
      for (int i = 0; i < 4; i++) chk("t2_order", xlog_pc[i], t1_pc[i]);

      // 3: redirect while the read of 0x8 is in flight
      redirect_to(32'h0);
      step(3);
      redirect_to(32'h103);
      step(6);
      chk("t3_issue", first_issue, 32'h100);
      chk("t3_xfer", xlog_pc[0], 32'h100);
      chk("t3_latency", 32'(lat), 32'(EXP_LAT));

      // 4: redirect coincides with an accepted head
      chk("t4_valid_before", {31'h0, instr_valid}, 32'h1);
      redirect_to(32'h100);
      step(6);
      chk("t4_xfer0", xlog_pc[0], 32'h100);
      chk("t4_xfer1", xlog_pc[1], 32'h104);

      // 5: fetch_en off drains the outstanding word, then resumes at the next address
      fetch_en = 1'b0;
      mark_id++;
      step(6);
      chk("t5_no_issue", 32'(n_issue), 32'd0);
      chk("t5_drained", 32'(n_xfer), 32'(EXP_T5));
      chk("t5_last_pc", xlog_pc[EXP_T5-1], 32'h114);
      fetch_en = 1'b1;
      mark_id++;
      step(6);
      chk("t5_resume", first_issue, 32'h118);

      // 5b: reset mid-stream
      chk("t5_valid_pre_rst", {31'h0, instr_valid}, 32'h1);
      resetn = 1'b0;
      #1;
      chk("t5_rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("t5_rst_ren", {31'h0, mem_renable}, 32'h0);
      step(2);
      resetn = 1'b1;
      mark_id++;
      step(6);
      chk("t5_rst_issue", first_issue, RESET_PC);
      chk("t5_rst_xfer", xlog_pc[0], RESET_PC);

      // Random traffic, including redirects near the top of the address space
      for (int i = 0; i < 3000; i++) begin
         fetch_en       = ($urandom_range(0, 9) != 0);
         instr_ready    = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 1) == 0) redirect_pc = $urandom;
         else redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
         if ($urandom_range(0, 599) == 0) resetn = 1'b0;
         else resetn = 1'b1;
         step(1);
      end
      redirect_valid = 1'b0;
      resetn = 1'b1;
      step(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
